// File: rtl/softmax_pkg.sv
// Shared types and defaults for the softmax streaming adapter.
// Element widths follow the LUT softmax core fixed-point formats.
`timescale 1ns/1ps
package softmax_pkg;

    localparam int DEF_DATACOUNT = 10;
    localparam int DEF_IN_W      = 8;
    localparam int DEF_OUT_W     = 16;
    localparam int DEF_CORE_LAT  = 1;

    // Most negative input: exp() of it is ~0, so padded slots vanish.
    localparam logic [DEF_IN_W-1:0] DEF_PAD_VAL = 8'h80;

    typedef logic [DEF_IN_W-1:0]  in_elem_t;
    typedef logic [DEF_OUT_W-1:0] out_elem_t;

    typedef enum logic [1:0] {
        FILL,
        COMPUTE,
        DRAIN
    } state_t;

endpackage

// File: rtl/softmax_stream_adapter.sv
// Element-stream front/back end around the parallel softmax core.
// Collects a frame, waits for the core to settle, then drains results.
`timescale 1ns/1ps
module softmax_stream_adapter
    import softmax_pkg::*;
#(
    parameter int DATACOUNT = DEF_DATACOUNT,
    parameter int IN_W      = DEF_IN_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int CORE_LAT  = DEF_CORE_LAT,
    parameter logic [IN_W-1:0] PAD_VAL = IN_W'(DEF_PAD_VAL)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_W-1:0]           in_data,
    input  logic                      in_last,
    output logic [DATACOUNT*IN_W-1:0] core_in,
    input  logic [DATACOUNT*OUT_W-1:0] core_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      frame_err
);

    localparam int IW = $clog2(DATACOUNT + 1);
    localparam int CW = (CORE_LAT < 2) ? 1 : $clog2(CORE_LAT + 1);
    localparam logic [IW-1:0] LAST_SLOT = IW'(DATACOUNT - 1);
    localparam logic [CW-1:0] LAT_INIT  = CW'(CORE_LAT);

    state_t            state;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     n_elem;
    logic [IW-1:0]     oidx;
    logic [CW-1:0]     wcnt;
    logic [IN_W-1:0]   slot     [DATACOUNT];
    logic [OUT_W-1:0]  obuf     [DATACOUNT];
    logic [OUT_W-1:0]  core_res [DATACOUNT];

    logic              accept;
    logic              close_now;
    logic [IW-1:0]     last_oidx;
    logic [IW-1:0]     next_oidx;

    for (genvar g = 0; g < DATACOUNT; g++) begin : g_pack
        assign core_in[g*IN_W +: IN_W] = slot[g];
        assign core_res[g] = core_out[g*OUT_W +: OUT_W];
    end

    assign in_ready  = (state == FILL);
    assign busy      = (state != FILL);
    assign accept    = in_valid && in_ready;
    assign close_now = in_last || (idx == LAST_SLOT);
    assign last_oidx = n_elem - IW'(1);
    assign next_oidx = oidx + IW'(1);

    // Frame collection, settle countdown, result capture and drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            idx       <= '0;
            n_elem    <= '0;
            oidx      <= '0;
            wcnt      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            frame_err <= 1'b0;
            for (int j = 0; j < DATACOUNT; j++) begin
                slot[j] <= '0;
                obuf[j] <= '0;
            end
        end else begin
            frame_err <= 1'b0;
            unique case (state)
                FILL: begin
                    if (accept) begin
                        slot[idx] <= in_data;
                        if (close_now) begin
                            n_elem <= idx + IW'(1);
                            for (int j = 0; j < DATACOUNT; j++) begin
                                if (IW'(j) > idx) begin
                                    slot[j] <= PAD_VAL;
                                end
                            end
                            wcnt      <= LAT_INIT;
                            frame_err <= !in_last;
                            state     <= COMPUTE;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    wcnt <= wcnt - CW'(1);
                    if (wcnt == CW'(1)) begin
                        for (int j = 0; j < DATACOUNT; j++) begin
                            obuf[j] <= core_res[j];
                        end
                        oidx  <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= obuf[oidx];
                        out_last  <= (oidx == last_oidx);
                    end else if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            idx       <= '0;
                            state     <= FILL;
                        end else begin
                            oidx     <= next_oidx;
                            out_data <= obuf[next_oidx];
                            out_last <= (next_oidx == last_oidx);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_stream_adapter.sv
// Scoreboard bench for the softmax stream adapter with a pass-through core.
// Each stub result is the zero-extended input element of the same slot.
`timescale 1ns/1ps
module tb_softmax_stream_adapter;

    localparam int DC = 10;
    localparam int IW = 8;
    localparam int OW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IW-1:0]     in_data = '0;
    logic              in_last = 1'b0;
    logic [DC*IW-1:0]  core_in;
    logic [DC*OW-1:0]  core_out;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OW-1:0]     out_data;
    logic              out_last;
    logic              busy;
    logic              frame_err;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int close_cyc = 0;

    logic [IW-1:0] stim_q[$];
    logic [OW:0]   exp_q[$];

    softmax_stream_adapter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .core_in   (core_in),
        .core_out  (core_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .frame_err (frame_err)
    );

    for (genvar g = 0; g < DC; g++) begin : g_stub
        assign core_out[g*OW +: OW] = {8'h00, core_in[g*IW +: IW]};
    end

    always #5 clk = ~clk;

    // Cycle counter used for latency measurements.
    always @(posedge clk) cyc++;

    // Count every cycle frame_err is high.
    always @(negedge clk) if (frame_err) ferr_cnt++;

    // Hard stop if something hangs despite the bounded waits.
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input bit use_last);
        int n;
        int budget;
        n = stim_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = stim_q[i];
            in_last  = use_last && (i == n - 1);
            budget = 0;
            while (!in_ready && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            if (!in_ready) begin
                tests_run++;
                tests_failed++;
                $display("FAIL in_ready_timeout elem=%0d", i);
            end
            exp_q.push_back({(i == n - 1), 8'h00, stim_q[i]});
        end
        @(negedge clk);
        close_cyc = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(input int n, input bit stall,
                           input bit chk_lat, input bit chk_end);
        int got;
        int k;
        int budget;
        bit first;
        bit stalled;
        logic [OW-1:0] held;
        logic [OW:0]   e;
        got = 0; k = 0; budget = 0;
        first = 1'b1; stalled = 1'b0; held = '0;
        while (got < n && budget < 500) begin
            @(negedge clk);
            budget++;
            if (out_valid && first) begin
                first = 1'b0;
                if (chk_lat) begin
                    tests_run++;
                    if ((cyc - close_cyc) !== 2) begin
                        tests_failed++;
                        $display("FAIL latency got=%0d exp=2", cyc - close_cyc);
                    end
                end
            end
            if (stalled) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    tests_failed++;
                    $display("FAIL stall_hold valid=%b data=%h exp=%h",
                             out_valid, out_data, held);
                end
            end
            if (out_valid) begin
                out_ready = stall ? (k % 3 == 0) : 1'b1;
                k++;
                tests_run++;
                if (in_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL in_ready_drain got=%b exp=0", in_ready);
                end
            end else begin
                out_ready = stall ? 1'b0 : 1'b1;
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL extra_output data=%h", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e[OW-1:0] || out_last !== e[OW]) begin
                        tests_failed++;
                        $display("FAIL out_elem got=%h/%b exp=%h/%b",
                                 out_data, out_last, e[OW-1:0], e[OW]);
                    end
                end
                got++;
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                held = out_data;
            end
        end
        if (got < n) begin
            tests_run++;
            tests_failed++;
            $display("FAIL collect_timeout got=%0d exp=%0d", got, n);
        end
        if (chk_end) begin
            @(negedge clk);
            out_ready = 1'b0;
            tests_run++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
                tests_failed++;
                $display("FAIL drain_end valid=%b busy=%b left=%0d exp=0/0/0",
                         out_valid, busy, exp_q.size());
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
            busy !== 1'b0 || frame_err !== 1'b0 || in_ready !== 1'b1 ||
            core_in !== '0) begin
            tests_failed++;
            $display("FAIL reset_state v=%b d=%h l=%b b=%b fe=%b ir=%b core=%h",
                     out_valid, out_data, out_last, busy, frame_err,
                     in_ready, core_in);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_frame;
        int f0;
        f0 = ferr_cnt;
        stim_q.delete();
        for (int i = 1; i <= DC; i++) stim_q.push_back(IW'(i));
        send_frame(1'b1);
        collect(DC, 1'b0, 1'b1, 1'b1);
        tests_run++;
        if (ferr_cnt - f0 !== 0) begin
            tests_failed++;
            $display("FAIL full_frame_err got=%0d exp=0", ferr_cnt - f0);
        end
    endtask

    task automatic test_short_frame;
        logic [IW-1:0] want;
        stim_q.delete();
        stim_q.push_back(8'h10);
        stim_q.push_back(8'h20);
        stim_q.push_back(8'h30);
        send_frame(1'b1);
        for (int s = 0; s < DC; s++) begin
            want = (s < 3) ? stim_q[s] : 8'h80;
            tests_run++;
            if (core_in[s*IW +: IW] !== want) begin
                tests_failed++;
                $display("FAIL pad_slot%0d got=%h exp=%h",
                         s, core_in[s*IW +: IW], want);
            end
        end
        collect(3, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_no_last;
        int f0;
        f0 = ferr_cnt;
        stim_q.delete();
        for (int i = 0; i < DC; i++) stim_q.push_back(IW'(8'h40 + i));
        send_frame(1'b0);
        collect(DC, 1'b0, 1'b1, 1'b1);
        tests_run++;
        if (ferr_cnt - f0 !== 1) begin
            tests_failed++;
            $display("FAIL frame_err_pulses got=%0d exp=1", ferr_cnt - f0);
        end
        stim_q.delete();
        stim_q.push_back(8'h5A);
        send_frame(1'b1);
        tests_run++;
        if (core_in[IW-1:0] !== 8'h5A || core_in[2*IW-1:IW] !== 8'h80) begin
            tests_failed++;
            $display("FAIL next_frame_slot0 got=%h/%h exp=5a/80",
                     core_in[IW-1:0], core_in[2*IW-1:IW]);
        end
        collect(1, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back_stall;
        stim_q.delete();
        for (int i = 0; i < DC; i++) stim_q.push_back(IW'($urandom_range(0, 255)));
        send_frame(1'b1);
        collect(DC, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_drain;
        stim_q.delete();
        for (int i = 0; i < DC; i++) stim_q.push_back(IW'(8'hA0 + i));
        send_frame(1'b1);
        collect(4, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 ||
            out_data !== '0 || in_ready !== 1'b1 || core_in !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset v=%b b=%b l=%b d=%h ir=%b core=%h",
                     out_valid, busy, out_last, out_data, in_ready, core_in);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        stim_q.delete();
        for (int i = 0; i < DC; i++) stim_q.push_back(IW'(8'hF6 + i));
        send_frame(1'b1);
        collect(DC, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset;
        test_full_frame;
        test_short_frame;
        test_no_last;
        test_back_to_back_stall;
        test_reset_mid_drain;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
